// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Holds the FSM state encoding, the memory-owner encoding and the
// legal-range check for the latency and starvation parameters.
package dmem_port_arbiter_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY_CPU = 2'd1,
        ST_BUSY_EXT = 2'd2,
        ST_EXT_RESP = 2'd3
    } arb_state_e;

    // Which requester drives the memory in the current cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_EXT  = 2'd2
    } owner_e;

    localparam int unsigned MEM_LAT_MIN    = 32'd1;
    localparam int unsigned MEM_LAT_MAX    = 32'd4;
    localparam int unsigned STARVE_MIN     = 32'd1;
    localparam int unsigned STARVE_MAX_LIM = 32'd15;

    // True when both parameters are inside the range the counters are sized for.
    function automatic bit params_legal(input int unsigned lat, input int unsigned stv);
        return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX) &&
               (stv >= STARVE_MIN)  && (stv <= STARVE_MAX_LIM);
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the MEM stage, the external requester and the
// data memory instance. The arbiter uses the slave view; the
// surrounding system (or bench) uses the master view.
interface dmem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    // CPU (MEM stage) side
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;
    // External requester side
    logic              ext_req;
    logic              ext_we;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic              ext_gnt;
    logic [DATA_W-1:0] ext_rdata;
    logic              ext_rvalid;
    // Memory instance side
    logic              mem_MemRead;
    logic              mem_MemWrite;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] mem_rd;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        output ext_gnt, ext_rdata, ext_rvalid,
        output mem_MemRead, mem_MemWrite, mem_addr, mem_wd,
        input  mem_rd
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output ext_req, ext_we, ext_addr, ext_wdata,
        input  ext_gnt, ext_rdata, ext_rvalid,
        input  mem_MemRead, mem_MemWrite, mem_addr, mem_wd,
        output mem_rd
    );

endinterface

// File: rtl/dmem_lat_counter.sv
// Access-latency counter. Counts the cycles of the access in progress and
// flags the completion cycle (cnt == MEM_LAT-1). It sits at zero whenever
// nobody owns the memory, so every new grant starts from cnt = 0.
module dmem_lat_counter #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_active,
    output logic o_done
);

    logic [1:0] r_cnt;

    assign o_done = i_active && (r_cnt == 2'(MEM_LAT - 32'd1));

    // Cycle counter: advance during an access, return to zero on completion or idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= 2'd0;
        end else if (!i_active || o_done) begin
            r_cnt <= 2'd0;
        end else begin
            r_cnt <= r_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Single-port data memory arbiter. The MEM stage has priority; the external
// requester is served when the CPU is idle, or ahead of the CPU once it has
// been refused STARVE_MAX consecutive cycles. Each access lasts MEM_LAT
// cycles and the pipeline is stalled until its own access completes.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    dmem_port_arbiter_if.slave bus
);

    if (!params_legal(MEM_LAT, STARVE_MAX)) begin : g_bad_param
        $error("dmem_port_arbiter: MEM_LAT must be 1..4 and STARVE_MAX 1..15");
    end

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    owner_e            w_owner;
    logic              w_active;
    logic              w_done;
    logic [3:0]        r_starve;
    logic [DATA_W-1:0] r_ext_rdata;
    logic              r_ext_rvalid;

    // Owner selection: continue a running access, otherwise arbitrate a new grant.
    // The owner is forced to none while reset is asserted so the strobes drop at once.
    always_comb begin
        w_owner = OWN_NONE;
        case (r_state)
            ST_IDLE: begin
                if (bus.ext_req && (r_starve == 4'(STARVE_MAX))) begin
                    w_owner = OWN_EXT;
                end else if (bus.cpu_req) begin
                    w_owner = OWN_CPU;
                end else if (bus.ext_req) begin
                    w_owner = OWN_EXT;
                end else begin
                    w_owner = OWN_NONE;
                end
            end
            ST_EXT_RESP: begin
                // The external requester must re-present its request, so it is ignored here.
                if (bus.cpu_req) begin
                    w_owner = OWN_CPU;
                end else begin
                    w_owner = OWN_NONE;
                end
            end
            ST_BUSY_CPU: w_owner = OWN_CPU;
            ST_BUSY_EXT: w_owner = OWN_EXT;
            default:     w_owner = OWN_NONE;
        endcase
        if (!rst) begin
            w_owner = OWN_NONE;
        end else begin
            w_owner = w_owner;
        end
    end

    assign w_active = (w_owner != OWN_NONE);

    dmem_lat_counter #(
        .MEM_LAT (MEM_LAT)
    ) u_lat_counter (
        .clk      (clk),
        .rst      (rst),
        .i_active (w_active),
        .o_done   (w_done)
    );

    // Next state: stay busy until the completion cycle, then free the port.
    always_comb begin
        w_state_nxt = ST_IDLE;
        case (w_owner)
            OWN_CPU: w_state_nxt = w_done ? ST_IDLE     : ST_BUSY_CPU;
            OWN_EXT: w_state_nxt = w_done ? ST_EXT_RESP : ST_BUSY_EXT;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Memory-side mux: the owner's fields drive the memory, strobes on every owned cycle.
    always_comb begin
        bus.mem_MemRead  = 1'b0;
        bus.mem_MemWrite = 1'b0;
        bus.mem_addr     = {ADDR_W{1'b0}};
        bus.mem_wd       = {DATA_W{1'b0}};
        case (w_owner)
            OWN_CPU: begin
                bus.mem_MemRead  = !bus.cpu_we;
                bus.mem_MemWrite = bus.cpu_we;
                bus.mem_addr     = bus.cpu_addr;
                bus.mem_wd       = bus.cpu_wdata;
            end
            OWN_EXT: begin
                bus.mem_MemRead  = !bus.ext_we;
                bus.mem_MemWrite = bus.ext_we;
                bus.mem_addr     = bus.ext_addr;
                bus.mem_wd       = bus.ext_wdata;
            end
            default: begin
                bus.mem_MemRead  = 1'b0;
                bus.mem_MemWrite = 1'b0;
            end
        endcase
    end

    assign bus.cpu_rdata  = bus.mem_rd;
    assign bus.cpu_stall  = rst && bus.cpu_req && !((w_owner == OWN_CPU) && w_done);
    assign bus.ext_gnt    = (w_owner == OWN_EXT);
    assign bus.ext_rdata  = r_ext_rdata;
    assign bus.ext_rvalid = r_ext_rvalid;

    // Starvation counter: counts refused external cycles, saturating; cleared on grant or idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve <= 4'd0;
        end else if (!bus.ext_req || (w_owner == OWN_EXT)) begin
            r_starve <= 4'd0;
        end else if ((r_state != ST_EXT_RESP) && (r_starve < 4'(STARVE_MAX))) begin
            r_starve <= r_starve + 4'd1;
        end else begin
            r_starve <= r_starve;
        end
    end

    // External response: capture read data and pulse rvalid after the completion cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ext_rdata  <= {DATA_W{1'b0}};
            r_ext_rvalid <= 1'b0;
        end else if ((w_owner == OWN_EXT) && w_done) begin
            r_ext_rdata  <= bus.mem_rd;
            r_ext_rvalid <= 1'b1;
        end else begin
            r_ext_rdata  <= r_ext_rdata;
            r_ext_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter. Three instances (MEM_LAT = 1, 2, 3; STARVE_MAX = 4)
// each with a small word memory. A vector table exercises the single-cycle
// instance; hand-written sequences cover reset mid-access, multi-cycle CPU and
// external accesses, and an external request dropped mid-access.
module tb_dmem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter_if bus_a ();
    dmem_port_arbiter_if bus_b ();
    dmem_port_arbiter_if bus_c ();

    dmem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    dmem_port_arbiter #(.MEM_LAT(2), .STARVE_MAX(4)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
    dmem_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

    logic [31:0] mem_a [0:63] = '{default: 32'h0};
    logic [31:0] mem_b [0:63] = '{default: 32'h0};
    logic [31:0] mem_c [0:63] = '{default: 32'h0};
    logic        ld_en   = 1'b0;
    logic [5:0]  ld_idx  = 6'd0;
    logic [31:0] ld_data = 32'h0;

    assign bus_a.mem_rd = mem_a[bus_a.mem_addr[7:2]];
    assign bus_b.mem_rd = mem_b[bus_b.mem_addr[7:2]];
    assign bus_c.mem_rd = mem_c[bus_c.mem_addr[7:2]];

    always @(posedge clk) begin
        if (ld_en) begin
            mem_a[ld_idx] <= ld_data;
            mem_b[ld_idx] <= ld_data;
            mem_c[ld_idx] <= ld_data;
        end else begin
            if (bus_a.mem_MemWrite) mem_a[bus_a.mem_addr[7:2]] <= bus_a.mem_wd;
            if (bus_b.mem_MemWrite) mem_b[bus_b.mem_addr[7:2]] <= bus_b.mem_wd;
            if (bus_c.mem_MemWrite) mem_c[bus_c.mem_addr[7:2]] <= bus_c.mem_wd;
        end
    end

    typedef struct {
        logic        cpu_req;
        logic [31:0] cpu_addr;
        logic        ext_req;
        logic [31:0] ext_addr;
        logic        exp_stall;
        logic        exp_gnt;
        logic        exp_rvalid;
        logic        exp_rd;
        logic        exp_wr;
        logic [31:0] exp_cpu_rdata;
        logic [31:0] exp_ext_rdata;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // idle inputs on every bus
        bus_a.cpu_req = 1'b0; bus_a.cpu_we = 1'b0; bus_a.cpu_addr = 32'h0; bus_a.cpu_wdata = 32'h0;
        bus_a.ext_req = 1'b0; bus_a.ext_we = 1'b0; bus_a.ext_addr = 32'h0; bus_a.ext_wdata = 32'h0;
        bus_b.cpu_req = 1'b0; bus_b.cpu_we = 1'b0; bus_b.cpu_addr = 32'h0; bus_b.cpu_wdata = 32'h0;
        bus_b.ext_req = 1'b0; bus_b.ext_we = 1'b0; bus_b.ext_addr = 32'h0; bus_b.ext_wdata = 32'h0;
        bus_c.cpu_req = 1'b0; bus_c.cpu_we = 1'b0; bus_c.cpu_addr = 32'h0; bus_c.cpu_wdata = 32'h0;
        bus_c.ext_req = 1'b0; bus_c.ext_we = 1'b0; bus_c.ext_addr = 32'h0; bus_c.ext_wdata = 32'h0;

        // vector table for the MEM_LAT=1 instance: lw, then 5 cycles of contention
        //               creq caddr   ereq eaddr   stl gnt rv  rd  wr  cpu_rdata      ext_rdata
        tbl[0] = '{1'b0, 32'h00, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 32'h0000};
        tbl[1] = '{1'b1, 32'h10, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0000};
        tbl[2] = '{1'b1, 32'h10, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0000};
        tbl[3] = '{1'b1, 32'h10, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0000};
        tbl[4] = '{1'b1, 32'h10, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0000};
        tbl[5] = '{1'b1, 32'h10, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0000};
        tbl[6] = '{1'b1, 32'h10, 1'b1, 32'h40, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h000055AA, 32'h0000};
        tbl[7] = '{1'b1, 32'h10, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 32'h55AA};
        tbl[8] = '{1'b1, 32'h10, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h55AA};
        tbl[9] = '{1'b0, 32'h00, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 32'h55AA};

        // preload memories while reset is held
        #1;
        ld_en = 1'b1; ld_idx = 6'd4;  ld_data = 32'hDEADBEEF;
        next_cycle();
        ld_idx = 6'd16; ld_data = 32'h000055AA;
        next_cycle();
        ld_en = 1'b0;

        // reset state, with a CPU request held to show the outputs are gated
        bus_a.cpu_req = 1'b1; bus_a.cpu_addr = 32'h10;
        @(negedge clk);
        chk("rst stall", bus_a.cpu_stall, 32'd0);
        chk("rst memread", bus_a.mem_MemRead, 32'd0);
        chk("rst gnt", bus_a.ext_gnt, 32'd0);
        chk("rst rvalid", bus_a.ext_rvalid, 32'd0);
        chk("rst ext_rdata", bus_a.ext_rdata, 32'd0);
        next_cycle();
        bus_a.cpu_req = 1'b0; bus_a.cpu_addr = 32'h0;
        rst = 1'b1;

        // T1: reset during BUSY_EXT on the MEM_LAT=3 instance
        bus_c.ext_req = 1'b1; bus_c.ext_we = 1'b0; bus_c.ext_addr = 32'h40;
        @(negedge clk);
        chk("t1 gnt issue", bus_c.ext_gnt, 32'd1);
        chk("t1 memread issue", bus_c.mem_MemRead, 32'd1);
        next_cycle();
        @(negedge clk);
        chk("t1 gnt cnt1", bus_c.ext_gnt, 32'd1);
        #1;
        rst = 1'b0;
        bus_c.ext_req = 1'b0;
        #1;
        chk("t1 memread in rst", bus_c.mem_MemRead, 32'd0);
        chk("t1 memwrite in rst", bus_c.mem_MemWrite, 32'd0);
        chk("t1 gnt in rst", bus_c.ext_gnt, 32'd0);
        next_cycle();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("t1 no rvalid %0d", k), bus_c.ext_rvalid, 32'd0);
            next_cycle();
        end
        // a fresh CPU load must see the full 3-cycle sequence from IDLE
        bus_c.cpu_req = 1'b1; bus_c.cpu_we = 1'b0; bus_c.cpu_addr = 32'h40;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("t1 lw stall %0d", k), bus_c.cpu_stall, (k < 2) ? 32'd1 : 32'd0);
            chk($sformatf("t1 lw memread %0d", k), bus_c.mem_MemRead, 32'd1);
            next_cycle();
        end
        bus_c.cpu_req = 1'b0;

        // T2/T5: table on the MEM_LAT=1 instance
        for (int i = 0; i < 10; i++) begin
            bus_a.cpu_req  = tbl[i].cpu_req;
            bus_a.cpu_we   = 1'b0;
            bus_a.cpu_addr = tbl[i].cpu_addr;
            bus_a.ext_req  = tbl[i].ext_req;
            bus_a.ext_we   = 1'b0;
            bus_a.ext_addr = tbl[i].ext_addr;
            @(negedge clk);
            chk($sformatf("v%0d stall", i),     bus_a.cpu_stall,    32'(tbl[i].exp_stall));
            chk($sformatf("v%0d gnt", i),       bus_a.ext_gnt,      32'(tbl[i].exp_gnt));
            chk($sformatf("v%0d rvalid", i),    bus_a.ext_rvalid,   32'(tbl[i].exp_rvalid));
            chk($sformatf("v%0d memread", i),   bus_a.mem_MemRead,  32'(tbl[i].exp_rd));
            chk($sformatf("v%0d memwrite", i),  bus_a.mem_MemWrite, 32'(tbl[i].exp_wr));
            chk($sformatf("v%0d cpu_rdata", i), bus_a.cpu_rdata,    tbl[i].exp_cpu_rdata);
            chk($sformatf("v%0d ext_rdata", i), bus_a.ext_rdata,    tbl[i].exp_ext_rdata);
            next_cycle();
        end

        // T4: external read on the MEM_LAT=2 instance, CPU granted in EXT_RESP
        bus_b.ext_req = 1'b1; bus_b.ext_we = 1'b0; bus_b.ext_addr = 32'h40;
        @(negedge clk);
        chk("t4 gnt c1", bus_b.ext_gnt, 32'd1);
        chk("t4 memread c1", bus_b.mem_MemRead, 32'd1);
        chk("t4 rvalid c1", bus_b.ext_rvalid, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("t4 gnt c2", bus_b.ext_gnt, 32'd1);
        chk("t4 rvalid c2", bus_b.ext_rvalid, 32'd0);
        next_cycle();
        bus_b.ext_req = 1'b0;
        bus_b.cpu_req = 1'b1; bus_b.cpu_we = 1'b0; bus_b.cpu_addr = 32'h10;
        @(negedge clk);
        chk("t4 rvalid resp", bus_b.ext_rvalid, 32'd1);
        chk("t4 ext_rdata", bus_b.ext_rdata, 32'h55AA);
        chk("t4 gnt resp", bus_b.ext_gnt, 32'd0);
        chk("t4 cpu memread resp", bus_b.mem_MemRead, 32'd1);
        chk("t4 cpu stall resp", bus_b.cpu_stall, 32'd1);
        next_cycle();
        @(negedge clk);
        chk("t4 cpu stall done", bus_b.cpu_stall, 32'd0);
        chk("t4 cpu_rdata", bus_b.cpu_rdata, 32'hDEADBEEF);
        chk("t4 rvalid after", bus_b.ext_rvalid, 32'd0);
        next_cycle();
        bus_b.cpu_req = 1'b0;

        // T3: CPU store then load on the MEM_LAT=3 instance
        bus_c.cpu_req = 1'b1; bus_c.cpu_we = 1'b1; bus_c.cpu_addr = 32'h20; bus_c.cpu_wdata = 32'h1234;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("t3 sw stall %0d", k), bus_c.cpu_stall, (k < 2) ? 32'd1 : 32'd0);
            chk($sformatf("t3 sw memwrite %0d", k), bus_c.mem_MemWrite, 32'd1);
            next_cycle();
        end
        bus_c.cpu_we = 1'b0; bus_c.cpu_wdata = 32'h0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("t3 lw stall %0d", k), bus_c.cpu_stall, (k < 2) ? 32'd1 : 32'd0);
            next_cycle();
        end
        bus_c.cpu_req = 1'b0;
        @(negedge clk);
        chk("t3 stored word", mem_c[8], 32'h1234);
        next_cycle();
        bus_c.cpu_req = 1'b1; bus_c.cpu_addr = 32'h20;
        @(negedge clk);
        chk("t3 readback", bus_c.cpu_rdata, 32'h1234);
        next_cycle();
        bus_c.cpu_req = 1'b1;
        next_cycle();
        next_cycle();
        bus_c.cpu_req = 1'b0;

        // T6: external write with ext_req dropped after the issue cycle
        bus_c.ext_req = 1'b1; bus_c.ext_we = 1'b1; bus_c.ext_addr = 32'h30; bus_c.ext_wdata = 32'h77;
        @(negedge clk);
        chk("t6 gnt c1", bus_c.ext_gnt, 32'd1);
        chk("t6 memwrite c1", bus_c.mem_MemWrite, 32'd1);
        chk("t6 mem_wd c1", bus_c.mem_wd, 32'h77);
        next_cycle();
        bus_c.ext_req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("t6 gnt held %0d", k), bus_c.ext_gnt, 32'd1);
            chk($sformatf("t6 memwrite held %0d", k), bus_c.mem_MemWrite, 32'd1);
            chk($sformatf("t6 rvalid early %0d", k), bus_c.ext_rvalid, 32'd0);
            next_cycle();
        end
        @(negedge clk);
        chk("t6 rvalid", bus_c.ext_rvalid, 32'd1);
        chk("t6 gnt resp", bus_c.ext_gnt, 32'd0);
        chk("t6 memwrite resp", bus_c.mem_MemWrite, 32'd0);
        chk("t6 ext_rdata", bus_c.ext_rdata, 32'h77);
        next_cycle();
        @(negedge clk);
        chk("t6 rvalid once", bus_c.ext_rvalid, 32'd0);
        chk("t6 starve", 32'(dut_c.r_starve), 32'd0);
        chk("t6 written word", mem_c[12], 32'h77);
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
